// File: rtl/cla_pkg.sv
// Shared widths and FSM state encoding for the sequential CLA add/subtract unit.
package cla_pkg;

   localparam int CLA_WIDTH = 64;
   localparam int CLA_SLICE = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Keeps the slice index at least one bit wide even for a single-slice build.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/CLA_Add16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second-level group lookahead.
// Purely combinational; carry-out comes from the group lookahead, not the ripple path.
module CLA_Add16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_c,
   output logic [15:0] o_s,
   output logic        o_c
);

   logic [15:0] w_g;
   logic [15:0] w_p;
   logic [15:0] w_c;
   logic [3:0]  w_gg;
   logic [3:0]  w_gp;
   logic [4:0]  w_gc;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   always_comb begin
      w_gg = '0;
      w_gp = '0;
      for (int j = 0; j < 4; j++) begin
         w_gp[j] = &w_p[4*j +: 4];
         w_gg[j] = w_g[4*j+3]
                 | (w_p[4*j+3] & w_g[4*j+2])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      end
   end

   // Second-level lookahead: carry into each 4-bit group straight from i_c.
   assign w_gc[0] = i_c;
   assign w_gc[1] = w_gg[0] | (w_gp[0] & i_c);
   assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_c);
   assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & i_c);
   assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_c);

   always_comb begin
      w_c = '0;
      for (int j = 0; j < 4; j++) begin
         w_c[4*j] = w_gc[j];
         for (int i = 0; i < 3; i++) begin
            w_c[4*j+i+1] = w_g[4*j+i] | (w_p[4*j+i] & w_c[4*j+i]);
         end
      end
   end

   assign o_s = w_p ^ w_c;
   assign o_c = w_gc[4];

endmodule

// File: rtl/cla_seq_add64.sv
// Multi-cycle WIDTH-bit add/subtract that walks one shared 16-bit CLA slice LSB-first,
// one slice per clock, chaining the carry through a register; done pulses after NSLICE RUN edges.
module cla_seq_add64
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int SLICE = CLA_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cIn,
   output logic [WIDTH-1:0] s,
   output logic             cOut,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = idx_width(NSLICE);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   if (SLICE != 16 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("cla_seq_add64: SLICE must be 16 and divide WIDTH");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDXW-1:0]  r_idx;
   logic             r_carry;
   logic [WIDTH-1:0] r_xa;
   logic [WIDTH-1:0] r_yb;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ovf;
   logic             r_busy;
   logic             r_done;

   logic             w_accept;
   logic             w_last;
   logic [SLICE-1:0] w_a;
   logic [SLICE-1:0] w_b;
   logic [SLICE-1:0] w_sum;
   logic             w_cout;

   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_idx == LAST_IDX);
   assign w_a      = r_xa[r_idx*SLICE +: SLICE];
   assign w_b      = r_yb[r_idx*SLICE +: SLICE];

   CLA_Add16 u_slice (
      .i_a (w_a),
      .i_b (w_b),
      .i_c (r_carry),
      .o_s (w_sum),
      .o_c (w_cout)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == S_RUN);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_xa    <= '0;
         r_yb    <= '0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         // Subtraction is x + ~y + 1; the +1 rides in as the first slice's carry.
         r_xa    <= x;
         r_yb    <= op ? ~y : y;
         r_carry <= op ? 1'b1 : cIn;
         r_idx   <= '0;
      end else if (r_state == S_RUN) begin
         r_s[r_idx*SLICE +: SLICE] <= w_sum;
         r_carry <= w_cout;
         r_idx   <= r_idx + 1'b1;
         if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= (r_xa[WIDTH-1] == r_yb[WIDTH-1]) && (w_sum[SLICE-1] != r_xa[WIDTH-1]);
         end
      end
   end

   assign s    = r_s;
   assign cOut = r_cout;
   assign ovf  = r_ovf;
   assign busy = r_busy;
   assign done = r_done;

endmodule
